// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// ALUSrc immediate select, load-use hazard detection and a bubble counter.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] RS1data_i,
  input  logic [WIDTH-1:0] RS2data_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             MemtoReg_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             EXMEM_RegWrite_i,
  input  logic [4:0]       EXMEM_RDaddr_i,
  input  logic [WIDTH-1:0] EXMEM_data_i,
  input  logic             MEMWB_RegWrite_i,
  input  logic [4:0]       MEMWB_RDaddr_i,
  input  logic [WIDTH-1:0] MEMWB_data_i,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] data2_o,
  output logic [2:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] MemWdata_o,
  output logic [4:0]       RDaddr_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             valid_o,
  output logic             hazard_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic             valid_q;
  logic             reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q;
  logic [2:0]       alu_ctrl_q;
  logic [4:0]       rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [WIDTH-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [WIDTH-1:0] fwd1, fwd2;
  logic             hazard;

  assign valid_o    = valid_q;
  assign RegWrite_o = reg_write_q & valid_q;
  assign MemRead_o  = mem_read_q & valid_q;
  assign MemWrite_o = mem_write_q & valid_q;
  assign MemtoReg_o = mem_to_reg_q & valid_q;
  assign RDaddr_o   = rd_addr_q;
  assign ALUCtrl_o  = alu_ctrl_q;
  assign bubble_cnt_o = bubble_cnt_q;

  // A store reads rs2 as data even when ALUSrc picks the immediate.
  always_comb begin
    hazard = 1'b0;
    if (valid_q && mem_read_q && (rd_addr_q != 5'd0) && valid_i) begin
      hazard = (rd_addr_q == RS1addr_i) ||
               ((rd_addr_q == RS2addr_i) && (!ALUSrc_i || MemWrite_i));
    end
    if (stall_i || flush_i) hazard = 1'b0;
  end
  assign hazard_stall_o = hazard;

  // EX/MEM is younger than MEM/WB so it wins; x0 is never forwarded.
  always_comb begin
    fwd1 = rs1_data_q;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != 5'd0) && (EXMEM_RDaddr_i == rs1_addr_q))
      fwd1 = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != 5'd0) && (MEMWB_RDaddr_i == rs1_addr_q))
      fwd1 = MEMWB_data_i;
    fwd2 = rs2_data_q;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != 5'd0) && (EXMEM_RDaddr_i == rs2_addr_q))
      fwd2 = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != 5'd0) && (MEMWB_RDaddr_i == rs2_addr_q))
      fwd2 = MEMWB_data_i;
  end

  assign data1_o    = fwd1;
  assign data2_o    = alu_src_q ? imm_q : fwd2;
  assign MemWdata_o = fwd2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= 3'd0;
      rs1_addr_q   <= 5'd0;
      rs2_addr_q   <= 5'd0;
      rd_addr_q    <= 5'd0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      bubble_cnt_q <= '0;
    end else if (stall_i) begin
      // hold everything
    end else if (flush_i || hazard) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= 3'd0;
      rs1_addr_q   <= 5'd0;
      rs2_addr_q   <= 5'd0;
      rd_addr_q    <= 5'd0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      // hazard is already forced low under flush, so flush never counts
      if (hazard && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end else begin
      valid_q      <= valid_i;
      reg_write_q  <= RegWrite_i;
      mem_read_q   <= MemRead_i;
      mem_write_q  <= MemWrite_i;
      mem_to_reg_q <= MemtoReg_i;
      alu_src_q    <= ALUSrc_i;
      alu_ctrl_q   <= ALUCtrl_i;
      rs1_addr_q   <= RS1addr_i;
      rs2_addr_q   <= RS2addr_i;
      rd_addr_q    <= RDaddr_i;
      rs1_data_q   <= RS1data_i;
      rs2_data_q   <= RS2data_i;
      imm_q        <= imm_i;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding vector table plus hand-written
// hazard, stall/flush, saturation and reset sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, valid, alu_src, reg_write, mem_read, mem_write, mem_to_reg;
  logic        stall, flush, ex_rw, wb_rw;
  logic [31:0] rs1_data, rs2_data, imm, ex_data, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, ex_rd, wb_rd;
  logic [2:0]  alu_ctrl;

  logic [31:0] data1, data2, mem_wdata, s_data1, s_data2, s_mem_wdata;
  logic [2:0]  alu_ctrl_o, s_alu_ctrl_o;
  logic [4:0]  rd_addr_o, s_rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, hazard;
  logic        s_reg_write_o, s_mem_read_o, s_mem_write_o, s_mem_to_reg_o, s_valid_o, s_hazard;
  logic [15:0] bubble_cnt;
  logic [3:0]  s_bubble_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .RS1data_i(rs1_data), .RS2data_i(rs2_data), .imm_i(imm),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RDaddr_i(rd_addr),
    .ALUCtrl_i(alu_ctrl), .ALUSrc_i(alu_src), .RegWrite_i(reg_write),
    .MemRead_i(mem_read), .MemWrite_i(mem_write), .MemtoReg_i(mem_to_reg),
    .stall_i(stall), .flush_i(flush),
    .EXMEM_RegWrite_i(ex_rw), .EXMEM_RDaddr_i(ex_rd), .EXMEM_data_i(ex_data),
    .MEMWB_RegWrite_i(wb_rw), .MEMWB_RDaddr_i(wb_rd), .MEMWB_data_i(wb_data),
    .data1_o(data1), .data2_o(data2), .ALUCtrl_o(alu_ctrl_o), .MemWdata_o(mem_wdata),
    .RDaddr_o(rd_addr_o), .RegWrite_o(reg_write_o), .MemRead_o(mem_read_o),
    .MemWrite_o(mem_write_o), .MemtoReg_o(mem_to_reg_o), .valid_o(valid_o),
    .hazard_stall_o(hazard), .bubble_cnt_o(bubble_cnt)
  );

  // Narrow-counter copy on the same inputs so saturation is reachable quickly.
  id_ex_stage #(.WIDTH(32), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .RS1data_i(rs1_data), .RS2data_i(rs2_data), .imm_i(imm),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RDaddr_i(rd_addr),
    .ALUCtrl_i(alu_ctrl), .ALUSrc_i(alu_src), .RegWrite_i(reg_write),
    .MemRead_i(mem_read), .MemWrite_i(mem_write), .MemtoReg_i(mem_to_reg),
    .stall_i(stall), .flush_i(flush),
    .EXMEM_RegWrite_i(ex_rw), .EXMEM_RDaddr_i(ex_rd), .EXMEM_data_i(ex_data),
    .MEMWB_RegWrite_i(wb_rw), .MEMWB_RDaddr_i(wb_rd), .MEMWB_data_i(wb_data),
    .data1_o(s_data1), .data2_o(s_data2), .ALUCtrl_o(s_alu_ctrl_o), .MemWdata_o(s_mem_wdata),
    .RDaddr_o(s_rd_addr_o), .RegWrite_o(s_reg_write_o), .MemRead_o(s_mem_read_o),
    .MemWrite_o(s_mem_write_o), .MemtoReg_o(s_mem_to_reg_o), .valid_o(s_valid_o),
    .hazard_stall_o(s_hazard), .bubble_cnt_o(s_bubble_cnt)
  );

  typedef struct {
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, imm;
    logic        alusrc;
    logic [2:0]  ctrl;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
    logic [31:0] exp_d1, exp_d2, exp_mw;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                        input logic [2:0] op, input logic src, input logic rw,
                        input logic mr, input logic mw, input logic m2r);
    valid = 1'b1;
    rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
    rs1_data = d1; rs2_data = d2; imm = im;
    alu_ctrl = op; alu_src = src; reg_write = rw;
    mem_read = mr; mem_write = mw; mem_to_reg = m2r;
  endtask

  task automatic clr_fwd();
    ex_rw = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
    wb_rw = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 3'd3,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7};
    vecs[1] = '{5'd3, 5'd0, 32'd10, 32'd0, 32'd0, 1'b0, 3'd3,
                1'b1, 5'd3, 32'h20, 1'b1, 5'd3, 32'h30, 32'h20, 32'd0, 32'd0};
    vecs[2] = '{5'd3, 5'd0, 32'd10, 32'd0, 32'd0, 1'b0, 3'd3,
                1'b0, 5'd3, 32'h20, 1'b1, 5'd3, 32'h30, 32'h30, 32'd0, 32'd0};
    vecs[3] = '{5'd3, 5'd0, 32'd10, 32'd0, 32'd0, 1'b0, 3'd3,
                1'b1, 5'd0, 32'h20, 1'b1, 5'd0, 32'h30, 32'd10, 32'd0, 32'd0};
    vecs[4] = '{5'd1, 5'd5, 32'd1, 32'd9, 32'hFFFFFFFC, 1'b1, 3'd6,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55, 32'd1, 32'hFFFFFFFC, 32'h55};
    vecs[5] = '{5'd7, 5'd7, 32'h11, 32'h22, 32'd0, 1'b0, 3'd1,
                1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'h99, 32'hAA, 32'hAA, 32'hAA};
    vecs[6] = '{5'd9, 5'd8, 32'h1, 32'h2, 32'd0, 1'b0, 3'd5,
                1'b1, 5'd8, 32'hCC, 1'b1, 5'd9, 32'hBB, 32'hBB, 32'hCC, 32'hCC};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    clr_fwd();
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data1", data1, 32'd0);
    chk("rst_data2", data2, 32'd0);
    chk("rst_regwrite", {31'd0, reg_write_o}, 32'd0);
    chk("rst_rdaddr", {27'd0, rd_addr_o}, 32'd0);
    chk("rst_aluctrl", {29'd0, alu_ctrl_o}, 32'd0);
    chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      set_id(vecs[i].rs1a, vecs[i].rs2a, 5'd10, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm,
             vecs[i].ctrl, vecs[i].alusrc, 1'b1, 1'b0, 1'b0, 1'b0);
      clr_fwd();
      step();
      valid = 1'b0;
      ex_rw = vecs[i].ex_rw; ex_rd = vecs[i].ex_rd; ex_data = vecs[i].ex_d;
      wb_rw = vecs[i].wb_rw; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_d;
      #1;
      chk($sformatf("v%0d_data1", i), data1, vecs[i].exp_d1);
      chk($sformatf("v%0d_data2", i), data2, vecs[i].exp_d2);
      chk($sformatf("v%0d_memwdata", i), mem_wdata, vecs[i].exp_mw);
      chk($sformatf("v%0d_aluctrl", i), {29'd0, alu_ctrl_o}, {29'd0, vecs[i].ctrl});
      chk($sformatf("v%0d_valid", i), {31'd0, valid_o}, 32'd1);
      chk($sformatf("v%0d_regwrite", i), {31'd0, reg_write_o}, 32'd1);
      chk($sformatf("v%0d_rdaddr", i), {27'd0, rd_addr_o}, 32'd10);
    end

    // Load-use: lw x4 in EX, dependent add in ID.
    clr_fwd();
    set_id(5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'd8, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("lw_memread", {31'd0, mem_read_o}, 32'd1);
    chk("lw_memtoreg", {31'd0, mem_to_reg_o}, 32'd1);
    set_id(5'd4, 5'd5, 5'd6, 32'd3, 32'd4, 32'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("hz_rs1", {31'd0, hazard}, 32'd1);
    set_id(5'd1, 5'd4, 5'd6, 32'd3, 32'd4, 32'd0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("hz_rs2_imm", {31'd0, hazard}, 32'd0);
    mem_write = 1'b1;
    #1 chk("hz_rs2_store", {31'd0, hazard}, 32'd1);
    mem_write = 1'b0; alu_src = 1'b0;
    #1 chk("hz_rs2_reg", {31'd0, hazard}, 32'd1);
    valid = 1'b0;
    #1 chk("hz_id_invalid", {31'd0, hazard}, 32'd0);
    set_id(5'd4, 5'd5, 5'd6, 32'd3, 32'd4, 32'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exp_cnt = 1;
    chk("bub_valid", {31'd0, valid_o}, 32'd0);
    chk("bub_regwrite", {31'd0, reg_write_o}, 32'd0);
    chk("bub_memread", {31'd0, mem_read_o}, 32'd0);
    chk("bub_rdaddr", {27'd0, rd_addr_o}, 32'd0);
    chk("bub_cnt", {16'd0, bubble_cnt}, exp_cnt);
    chk("bub_hazard", {31'd0, hazard}, 32'd0);
    step();
    chk("after_bub_valid", {31'd0, valid_o}, 32'd1);
    chk("after_bub_rdaddr", {27'd0, rd_addr_o}, 32'd6);
    chk("after_bub_data1", data1, 32'd3);

    // A load to x0 never creates a hazard.
    set_id(5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_id(5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("hz_x0", {31'd0, hazard}, 32'd0);

    // Stall holds everything, including a pending hazard.
    set_id(5'd2, 5'd3, 5'd9, 32'h1234, 32'h5678, 32'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_id(5'd9, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    #1 chk("stall_hazard_masked", {31'd0, hazard}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      rs1_data = $urandom_range(0, 32'hFFFF);
      rd_addr = 5'($urandom_range(1, 31));
      step();
      chk($sformatf("stall%0d_data1", c), data1, 32'h1234);
      chk($sformatf("stall%0d_data2", c), data2, 32'h5678);
      chk($sformatf("stall%0d_rdaddr", c), {27'd0, rd_addr_o}, 32'd9);
      chk($sformatf("stall%0d_valid", c), {31'd0, valid_o}, 32'd1);
      chk($sformatf("stall%0d_aluctrl", c), {29'd0, alu_ctrl_o}, 32'd4);
      chk($sformatf("stall%0d_cnt", c), {16'd0, bubble_cnt}, exp_cnt);
    end
    stall = 1'b0; flush = 1'b1;
    set_id(5'd9, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("flush_hazard_masked", {31'd0, hazard}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_memread", {31'd0, mem_read_o}, 32'd0);
    chk("flush_rdaddr", {27'd0, rd_addr_o}, 32'd0);
    chk("flush_cnt", {16'd0, bubble_cnt}, exp_cnt);

    // Repeated lw x4 <- x4: every other edge inserts a bubble.
    set_id(5'd4, 5'd0, 5'd4, 32'd0, 32'd0, 32'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sat%0d_hazard", k), {31'd0, hazard}, 32'd1);
      step();
      step();
    end
    exp_cnt += 20;
    chk("sat_cnt16", {16'd0, bubble_cnt}, exp_cnt);
    chk("sat_cnt4", {28'd0, s_bubble_cnt}, 32'd15);
    chk("sat_hazard_pending", {31'd0, hazard}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", {31'd0, valid_o}, 32'd0);
    chk("rst2_cnt16", {16'd0, bubble_cnt}, 32'd0);
    chk("rst2_cnt4", {28'd0, s_bubble_cnt}, 32'd0);
    chk("rst2_hazard", {31'd0, hazard}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that directly feeds the ALU (data1/data2/ALUCtrl) in the 5-stage RV32 subset core.
- Latches decoded operands and control from ID.
- Resolves EX/MEM and MEM/WB forwarding, applies the ALUSrc immediate select, and detects load-use hazards (bubble insertion).
- Keeps a saturating bubble counter for performance debug.

Parameters:
- WIDTH, 32, datapath width.
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  ID holds a real instruction
- RS1data_i  in  WIDTH  register-file read data for rs1
- RS2data_i  in  WIDTH  register-file read data for rs2
- imm_i  in  WIDTH  sign-extended immediate
- RS1addr_i  in  5  rs1 index
- RS2addr_i  in  5  rs2 index
- RDaddr_i  in  5  rd index
- ALUCtrl_i  in  3  ALU op code (AND=0, XOR=1, SLL=2, ADD=3, SUB=4, MUL=5, ADDI=6, SRAI=7)
- ALUSrc_i  in  1  1 selects imm as operand 2
- RegWrite_i  in  1  control from decode
- MemRead_i  in  1  control from decode
- MemWrite_i  in  1  control from decode
- MemtoReg_i  in  1  control from decode
- stall_i  in  1  global pipeline hold
- flush_i  in  1  squash the instruction entering EX
- EXMEM_RegWrite_i  in  1  EX/MEM stage writes a register
- EXMEM_RDaddr_i  in  5  EX/MEM destination index
- EXMEM_data_i  in  WIDTH  EX/MEM ALU result
- MEMWB_RegWrite_i  in  1  MEM/WB stage writes a register
- MEMWB_RDaddr_i  in  5  MEM/WB destination index
- MEMWB_data_i  in  WIDTH  MEM/WB writeback value
- data1_o  out  WIDTH  ALU operand 1
- data2_o  out  WIDTH  ALU operand 2
- ALUCtrl_o  out  3  registered ALU op code
- MemWdata_o  out  WIDTH  forwarded rs2 (store data)
- RDaddr_o  out  5  registered rd index
- RegWrite_o  out  1  registered control, qualified by valid
- MemRead_o  out  1  registered control, qualified by valid
- MemWrite_o  out  1  registered control, qualified by valid
- MemtoReg_o  out  1  registered control, qualified by valid
- valid_o  out  1  EX holds a real instruction
- hazard_stall_o  out  1  load-use detected; ID/IF must hold
- bubble_cnt_o  out  CNT_W  bubbles inserted, saturating

Behaviour:
- Reset, synchronous on rst_i=1 at a clock edge: every register clears to 0, including valid, all controls, data, addresses, ALUCtrl and bubble_cnt. data1_o and data2_o therefore read 0.
- Register update priority per edge: rst_i > stall_i (hold all, counter unchanged) > flush_i (load bubble) > hazard_stall_o (load bubble, counter+1) > normal load of all ID inputs.
- Bubble: valid=0, RegWrite, MemRead, MemWrite and MemtoReg all 0, RDaddr=0. Data fields are don't-care and are cleared to 0.
- flush_i and a hazard in the same cycle: flush wins and the counter does not increment.
- Output controls are the stored controls ANDed with the stored valid.
- Hazard, combinational: hazard_stall_o = valid_o & MemRead_o & (RDaddr_o!=0) & valid_i & ((RDaddr_o==RS1addr_i) | (RDaddr_o==RS2addr_i & !ALUSrc_i) | (RDaddr_o==RS2addr_i & MemWrite_i)).
- hazard_stall_o is forced to 0 while stall_i or flush_i is 1.
- Forwarding, combinational on the registered rs addresses, independently for each of rs1 and rs2:
  - If EXMEM_RegWrite_i, EXMEM_RDaddr_i!=0 and EXMEM_RDaddr_i==rs, use EXMEM_data_i.
  - Else if MEMWB_RegWrite_i, MEMWB_RDaddr_i!=0 and the addresses match, use MEMWB_data_i.
  - Else use the latched register data.
  - EX/MEM always beats MEM/WB. x0 is never forwarded.
- data1_o = forwarded rs1.
- data2_o = ALUSrc ? latched imm : forwarded rs2.
- MemWdata_o = forwarded rs2, regardless of ALUSrc.
- Latency: ID inputs appear on the outputs one cycle after an accepted edge.
- Register-file same-cycle write-through is outside this block.
- bubble_cnt_o saturates at all-ones and never wraps. It is cleared only by reset.
- Reset mid-stall or mid-hazard: the cleared state is in effect the next cycle and hazard_stall_o drops to 0.

Test Plan:
- Reset, then load ADD rs1=1 (data 5), rs2=2 (data 7), no forwarding -> next cycle data1_o=5, data2_o=7, ALUCtrl_o=3, valid_o=1, RegWrite_o=1.
- EX holds rs1=3, RS1data=10; EXMEM rd=3 with data 0x20; MEMWB rd=3 with data 0x30; both RegWrite=1 -> data1_o=0x20. Drop EXMEM_RegWrite -> data1_o=0x30. Set all rd=0 -> data1_o=10.
- EX holds lw rd=4 (MemRead=1); ID has rs1=4 -> hazard_stall_o=1. Next edge: valid_o=0, RegWrite_o=0, bubble_cnt_o=1. Then hazard_stall_o=0 and the ID instruction loads on the following edge.
- ADDI ALUSrc=1, imm=0xFFFFFFFC, rs2 forwarded 0x55 via MEMWB -> data2_o=0xFFFFFFFC, MemWdata_o=0x55.
- stall_i=1 for 3 cycles with changing ID inputs -> all outputs unchanged and counter unchanged. flush_i=1 together with a hazard -> bubble loaded, counter unchanged.
- Force 65537 hazard bubbles (CNT_W=16) -> bubble_cnt_o=0xFFFF and stays there. Assert rst_i -> 0 and valid_o=0 next cycle.
